ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_picker.sv | 30 +++
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the RAM arbiter: FSM state encodings and default parameters.
package arb_pkg;

    localparam int ARB_NREQ_DEF     = 3;
    localparam int ARB_AW_DEF       = 8;
    localparam int ARB_DW_DEF       = 32;
    localparam int ARB_LOCK_MAX_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority picker: one-hot winner searching from last_owner+1.
module rr_picker
    import arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [NREQ-1:0] winner
);

    always_comb begin
        int unsigned idx;
        logic        found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Offset NREQ wraps back to last_owner itself, so it is checked last.
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = 32'(last_owner) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin single-port RAM arbiter with burst lock and 1-cycle registered grant.
// Optional macro ARB_FETCH_PRIO_EN gives requester 0 (CPU fetch) absolute priority.
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = ARB_NREQ_DEF,
    parameter int AW       = ARB_AW_DEF,
    parameter int DW       = ARB_DW_DEF,
    parameter int LOCK_MAX = ARB_LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] pick_req, pick_win;
    logic [IW-1:0]   pick_idx;
    logic            hold;

    always_comb begin
        pick_req = req;
`ifdef ARB_FETCH_PRIO_EN
        if (req[0]) begin
            pick_req    = '0;
            pick_req[0] = 1'b1;
        end
`endif
    end

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req        (pick_req),
        .last_owner (owner_q),
        .winner     (pick_win)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            if (pick_win[i]) pick_idx = IW'(i);
    end

    // cnt_q holds the number of consecutive grants to owner_q minus one.
    always_comb begin
        hold = (state_q != ST_IDLE) && req[owner_q] && lock[owner_q]
               && (cnt_q < CW'(LOCK_MAX - 1));
`ifdef ARB_FETCH_PRIO_EN
        if (req[0] && (owner_q != '0)) hold = 1'b0;
`endif
    end

    always_comb begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        owner_d = owner_q;
        cnt_d   = '0;
        if (hold) begin
            state_d = ST_LOCK;
            gnt_d   = gnt_q;
            cnt_d   = cnt_q + 1'b1;
        end else if (|req) begin
            state_d = ST_GRANT;
            gnt_d   = pick_win;
            owner_d = pick_idx;
            if ((state_q != ST_IDLE) && (pick_idx == owner_q))
                cnt_d = (cnt_q == CW'(LOCK_MAX)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign rvalid_d = gnt_q & req & ~we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rvalid_q <= '0;
            owner_q  <= IW'(NREQ - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                mem_en    = req[i];
                mem_we    = we[i] & req[i];
                mem_addr  = addr[i*AW +: AW];
                mem_wdata = wdata[i*DW +: DW];
            end
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = mem_rdata;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a read-data scoreboard and a behavioural RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, lock, we;
    logic [23:0] addr;
    logic [95:0] wdata;
    logic [2:0]  gnt, rvalid;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, busy;
    logic [7:0]  mem_addr;
    logic [31:0] ram [256];

    int          checks = 0;
    int          failures = 0;
    int          exp_w[$];
    logic [31:0] exp_d[$];

`ifdef ARB_FETCH_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    ram_arbiter #(.NREQ(3), .AW(8), .DW(32), .LOCK_MAX(16)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .addr(addr), .we(we),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge and settle any read the scoreboard expects now.
    task automatic cycle();
        int          w;
        logic [31:0] d;
        logic [2:0]  one;
        @(negedge clk);
        if (exp_w.size() > 0) begin
            w   = exp_w.pop_front();
            d   = exp_d.pop_front();
            one = 3'b001 << w;
            chk("rvalid", 64'(rvalid), 64'(one));
            chk("rdata", 64'(rdata), 64'(d));
        end else begin
            chk("rvalid_idle", 64'(rvalid), 64'd0);
        end
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic do_read(input int r, input logic [7:0] a, input logic [31:0] d);
        logic [2:0] one;
        one = 3'b001 << r;
        req = one; we = 3'b000; lock = 3'b000;
        addr[r*8 +: 8] = a;
        cycle();
        chk("read_gnt", 64'(gnt), 64'(one));
        chk("read_mem_en", 64'(mem_en), 64'd1);
        chk("read_mem_we", 64'(mem_we), 64'd0);
        chk("read_mem_addr", 64'(mem_addr), 64'(a));
        exp_w.push_back(r); exp_d.push_back(d);
        cycle();
        req = 3'b000;
        cycle();
        chk("read_idle_gnt", 64'(gnt), 64'd0);
        chk("read_idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int w;
        int last;
        logic [2:0] one;

        reset = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) ram[8'h30 + i] = 32'hA000_0000 + i;

        cycle();
        cycle();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        reset = 1'b1;
        cycle();

        // Single read by requester 1
        do_read(1, 8'h10, 32'hDEADBEEF);

        // Contention with all three requesting reads
        rst_pulse();
        addr = {8'h32, 8'h31, 8'h30};
        req = 3'b111; we = 3'b000;
        last = 2;
        for (int k = 0; k < 4; k++) begin
            cycle();
            w = PRIO ? 0 : (last + 1) % 3;
            one = 3'b001 << w;
            chk("contend_gnt", 64'(gnt), 64'(one));
            last = w;
            if (k < 3) begin
                exp_w.push_back(w);
                exp_d.push_back(32'hA000_0000 + 32'(w));
            end
        end
        req = 3'b000;
        cycle();
        chk("contend_idle", 64'(gnt), 64'd0);

        // Lock timeout: requester 2 locked writes while requester 0 waits
        rst_pulse();
        req = 3'b100; lock = 3'b100; we = 3'b101;
        addr = {8'h40, 8'h00, 8'h41};
        wdata = {32'h12345678, 32'h0, 32'hCAFEF00D};
        cycle();
        chk("lock_first_gnt", 64'(gnt), 64'b100);
        chk("lock_mem_we", 64'(mem_we), 64'd1);
        chk("lock_mem_wdata", 64'(mem_wdata), 64'h12345678);
        req = 3'b101;
        n = 1;
        cycle();
        while (gnt === 3'b100 && n < 40) begin
            n++;
            cycle();
        end
        chk("lock_run_len", 64'(n), PRIO ? 64'd1 : 64'd16);
        chk("lock_next_gnt", 64'(gnt), 64'b001);
        req = 3'b000; lock = 3'b000;
        cycle();
        chk("lock_idle", 64'(gnt), 64'd0);
        chk("lock_ram_written", 64'(ram[8'h40]), 64'h12345678);
        do_read(0, 8'h40, 32'h12345678);

        // Requester 1 locked; requester 0 arrives, then lock is released
        rst_pulse();
        req = 3'b010; lock = 3'b010; we = 3'b011;
        addr = {8'h00, 8'h50, 8'h51};
        cycle();
        chk("lock1_gnt", 64'(gnt), 64'b010);
        req = 3'b011;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("lock1_hold", 64'(gnt), PRIO ? 64'b001 : 64'b010);
            chk("lock1_busy", 64'(busy), 64'd1);
        end
        lock = 3'b000;
        cycle();
        chk("unlock_next", 64'(gnt), 64'b001);
        cycle();
        chk("unlock_rr", 64'(gnt), PRIO ? 64'b001 : 64'b010);
        req = 3'b000;
        cycle();
        chk("unlock_idle", 64'(gnt), 64'd0);

        // Reset while a read is granted
        req = 3'b010; we = 3'b000; addr = {8'h00, 8'h60, 8'h00};
        cycle();
        chk("rmid_gnt", 64'(gnt), 64'b010);
        reset = 1'b0;
        #1;
        chk("rmid_gnt0", 64'(gnt), 64'd0);
        chk("rmid_busy0", 64'(busy), 64'd0);
        chk("rmid_rvalid0", 64'(rvalid), 64'd0);
        chk("rmid_mem_en0", 64'(mem_en), 64'd0);
        req = 3'b000;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        cycle();
        chk("rmid_after_gnt", 64'(gnt), 64'd0);
        chk("rmid_after_busy", 64'(busy), 64'd0);

        // Request withdrawn before its grant cycle
        req = 3'b100; we = 3'b000; addr = {8'h70, 8'h00, 8'h00};
        @(posedge clk);
        #1;
        req = 3'b000;
        cycle();
        chk("wd_gnt", 64'(gnt), 64'b100);
        chk("wd_mem_en", 64'(mem_en), 64'd0);
        chk("wd_busy", 64'(busy), 64'd1);
        cycle();
        chk("wd_idle_gnt", 64'(gnt), 64'd0);
        chk("wd_idle_busy", 64'(busy), 64'd0);
        chk("sb_drained", 64'(exp_w.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
